spl_multi: RTL and testbench

- Multi-channel peak-programme meter with peak hold and proportional decay.
- Accepts a time-multiplexed stream of signed samples tagged by channel.
- Keeps a per-channel peak magnitude, hold timer and sticky clip flag, and provides registered readback of any channel's peak and log2 level.
- Sits after the I2S/decimator channel mux and feeds the LED/UART level display.

---
 rtl/spl_multi.sv | 143 ++++++++++++++
 tb/tb_spl_multi.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spl_multi.sv
// Multi-channel peak-programme meter: per-channel peak hold with proportional decay,
// sticky clip flags and registered readback of peak, log2 level and clip.
module spl_multi #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int HOLD        = 8,
  parameter int DECAY_SHIFT = 3,
  parameter int LVL_W       = $clog2(WIDTH + 1)
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    decay_en,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]        rd_peak,
  output logic [LVL_W-1:0]        rd_level,
  output logic                    rd_clip,
  output logic                    busy
);

  localparam int HOLD_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic              r_s1_valid;
  logic [CH_W-1:0]   r_s1_ch;
  logic [WIDTH-1:0]  r_s1_mag;
  logic              r_s1_clip;

  logic [WIDTH-1:0]  r_peak [CHANNELS];
  logic [HOLD_W-1:0] r_hold [CHANNELS];
  logic              r_clip [CHANNELS];

  logic [WIDTH-1:0]  w_mag;
  logic              w_in_ok;
  logic              w_rd_ok;
  logic [WIDTH-1:0]  w_dec  [CHANNELS];
  logic              w_hit  [CHANNELS];
  logic              w_cap  [CHANNELS];
  logic [WIDTH-1:0]  w_sel_peak;
  logic              w_sel_clip;
  logic [LVL_W-1:0]  w_sel_lvl;

  // Two's-complement negate without saturation: the most negative value maps to 2^(WIDTH-1).
  assign w_mag   = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
  assign w_in_ok = {1'b0, in_ch} < CH_LIM;
  assign w_rd_ok = {1'b0, rd_ch} < CH_LIM;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_mag   <= '0;
      r_s1_clip  <= 1'b0;
    end else if (clr) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_mag   <= '0;
      r_s1_clip  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid && w_in_ok;
      r_s1_ch    <= in_ch;
      r_s1_mag   <= w_mag;
      r_s1_clip  <= (in_data == MAX_POS) || (in_data == MAX_NEG);
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      logic [WIDTH-1:0] step;
      step = r_peak[c] >> DECAY_SHIFT;
      if (step == '0) step = {{(WIDTH-1){1'b0}}, 1'b1};
      w_dec[c] = (r_peak[c] > step) ? (r_peak[c] - step) : '0;
      w_hit[c] = r_s1_valid && (r_s1_ch == CH_W'(c));
      w_cap[c] = w_hit[c] && (r_s1_mag >= r_peak[c]);
    end
  end

  // Capture compares against the live peak, so back-to-back samples on one channel need no bypass.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_peak[c] <= '0;
        r_hold[c] <= '0;
        r_clip[c] <= 1'b0;
      end
    end else if (clr) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_peak[c] <= '0;
        r_hold[c] <= '0;
        r_clip[c] <= 1'b0;
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (w_cap[c]) begin
          r_peak[c] <= r_s1_mag;
          r_hold[c] <= HOLD_W'(HOLD);
        end else if (decay_en) begin
          if (r_hold[c] != '0)      r_hold[c] <= r_hold[c] - 1'b1;
          else if (r_peak[c] != '0) r_peak[c] <= w_dec[c];
        end
        if (w_hit[c] && r_s1_clip) r_clip[c] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_peak = '0;
    w_sel_clip = 1'b0;
    w_sel_lvl  = '0;
    if (w_rd_ok) begin
      w_sel_peak = r_peak[rd_ch];
      w_sel_clip = r_clip[rd_ch];
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (w_sel_peak[i]) w_sel_lvl = LVL_W'(i + 1);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rd_peak  <= '0;
      rd_level <= '0;
      rd_clip  <= 1'b0;
    end else if (clr) begin
      rd_peak  <= '0;
      rd_level <= '0;
      rd_clip  <= 1'b0;
    end else begin
      rd_peak  <= w_sel_peak;
      rd_level <= w_sel_lvl;
      rd_clip  <= w_sel_clip;
    end
  end

  assign busy = r_s1_valid;

endmodule

// File: tb/tb_spl_multi.sv
// Directed self-checking bench for spl_multi with hand-computed expectations.
module tb_spl_multi;

  logic               ck = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_ch = '0;
  logic signed [15:0] in_data = '0;
  logic               decay_en = 1'b0;
  logic [1:0]         rd_ch = '0;
  logic [15:0]        rd_peak;
  logic [4:0]         rd_level;
  logic               rd_clip;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  spl_multi #(.WIDTH(16), .CHANNELS(4), .HOLD(8), .DECAY_SHIFT(3)) dut (
    .ck(ck), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .decay_en(decay_en), .rd_ch(rd_ch), .rd_peak(rd_peak),
    .rd_level(rd_level), .rd_clip(rd_clip), .busy(busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic send(input int ch, input int data);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_data  = 16'(data);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    decay_en = 1'b1;
    repeat (n) step();
    decay_en = 1'b0;
  endtask

  task automatic rd(input int ch, input string tag, input int pk, input int lvl, input int clp);
    rd_ch = 2'(ch);
    step();
    chk({tag, "_peak"}, int'(rd_peak), pk);
    chk({tag, "_lvl"}, int'(rd_level), lvl);
    chk({tag, "_clip"}, int'(rd_clip), clp);
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 4; c++) rd(c, $sformatf("rst_ch%0d", c), 0, 0, 0);

    // Capture and latency: visible on the third edge, not before.
    rd_ch    = 2'd2;
    in_valid = 1'b1;
    in_ch    = 2'd2;
    in_data  = -16'sd1000;
    step();
    in_valid = 1'b0;
    chk("lat_busy", int'(busy), 1);
    chk("lat_e1", int'(rd_peak), 0);
    step();
    chk("lat_e2", int'(rd_peak), 0);
    step();
    chk("lat_e3", int'(rd_peak), 1000);
    chk("lat_lvl", int'(rd_level), 10);
    rd(0, "other0", 0, 0, 0);
    rd(1, "other1", 0, 0, 0);
    rd(3, "other3", 0, 0, 0);

    ticks(8);
    rd(2, "hold8", 1000, 10, 0);
    ticks(1); rd(2, "dec1", 875, 10, 0);
    ticks(1); rd(2, "dec2", 766, 10, 0);
    ticks(1); rd(2, "dec3", 671, 10, 0);

    send(3, 5);
    ticks(8);
    rd(3, "small_hold", 5, 3, 0);
    for (int k = 4; k >= 0; k--) begin
      ticks(1);
      rd(3, $sformatf("small_%0d", k), k, (k >= 4) ? 3 : (k >= 2) ? 2 : k, 0);
    end
    ticks(1); rd(3, "small_floor", 0, 0, 0);

    // Collision: ch0 at 500 with hold expired, ch3 at 800 decaying in the same cycle.
    clr = 1'b1; step(); clr = 1'b0;
    send(0, 500);
    send(3, 800);
    ticks(8);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd500;
    step();
    in_valid = 1'b0; decay_en = 1'b1;
    step();
    decay_en = 1'b0;
    rd(0, "coll_ch0", 500, 9, 0);
    rd(3, "coll_ch3", 700, 10, 0);
    ticks(8);
    rd(0, "coll_reload", 500, 9, 0);
    ticks(1);
    rd(0, "coll_decay", 438, 9, 0);

    send(1, -32768);
    rd(1, "clip_neg", 32768, 16, 1);
    send(1, 0);
    rd(1, "clip_sticky", 32768, 16, 1);
    send(2, 32767);
    rd(2, "clip_pos", 32767, 15, 1);
    clr = 1'b1; step(); clr = 1'b0;
    rd(1, "clr_ch1", 0, 0, 0);

    // Async reset between edges with samples streaming to every channel.
    send(0, 1234);
    rd_ch    = 2'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_ch = 2'(k); in_data = 16'(100 * (k + 1));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_peak", int'(rd_peak), 0);
    chk("arst_busy", int'(busy), 0);
    in_valid = 1'b0;
    step();
    #1 rst_n = 1'b1;
    rd_ch = 2'd1;
    step();
    for (int c = 0; c < 4; c++) rd(c, $sformatf("arst_ch%0d", c), 0, 0, 0);
    rd_ch    = 2'd1;
    in_valid = 1'b1; in_ch = 2'd1; in_data = -16'sd3;
    step();
    in_valid = 1'b0;
    chk("post_e1", int'(rd_peak), 0);
    step();
    chk("post_e2", int'(rd_peak), 0);
    step();
    chk("post_e3", int'(rd_peak), 3);
    chk("post_lvl", int'(rd_level), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
